// File: rtl/dsp_addsub_acc.sv
// dsp_addsub_acc: multi-channel signed add/sub/accumulate with saturation and a registered valid/ready output
module dsp_addsub_acc #(
  parameter int WIDTH = 48,
  parameter int NCH = 4,
  parameter bit SAT = 1,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [CHW-1:0]   in_ch,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CHW-1:0]   out_ch,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  logic [WIDTH-1:0] acc [NCH];
  logic [WIDTH-1:0] old, x, y, res;
  logic [WIDTH:0] sum;
  logic accept, is_acc, ch_ok, wr, ovf, res_ovf;
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign is_acc = in_op[1];
  assign ch_ok = 32'(in_ch) < NCH;
  assign wr = accept && is_acc && ch_ok;
  // Current value of the addressed channel; a coincident clear makes it read as zero
  always_comb begin
    old = '0;
    for (int i = 0; i < NCH; i++) if (in_ch == CHW'(i)) old = acc[i];
    if (acc_clr) old = '0;
  end
  // Sign-extended add/sub, overflow from the two top bits, optional clamping
  always_comb begin
    x = is_acc ? old : in_a;
    y = is_acc ? in_a : in_b;
    sum = in_op[0] ? {x[WIDTH-1], x} - {y[WIDTH-1], y} : {x[WIDTH-1], x} + {y[WIDTH-1], y};
    ovf = sum[WIDTH] ^ sum[WIDTH-1];
    res = (SAT && ovf) ? (sum[WIDTH] ? MINV : MAXV) : sum[WIDTH-1:0];
    res_ovf = ovf;
    if (is_acc && !ch_ok) begin
      res = '0;
      res_ovf = 1'b1;
    end
  end
  // Accumulator bank: the accepted channel takes the new result, clear zeroes the rest
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) for (int i = 0; i < NCH; i++) acc[i] <= '0;
    else for (int i = 0; i < NCH; i++)
      if (wr && in_ch == CHW'(i)) acc[i] <= res;
      else if (acc_clr) acc[i] <= '0;
  // One-entry output register: load on accept, drop valid once the consumer takes it
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_ch <= '0;
      out_data <= '0;
      out_ovf <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_ch <= in_ch;
      out_data <= res;
      out_ovf <= res_ovf;
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_dsp_addsub_acc.sv
// tb_dsp_addsub_acc: directed scoreboard bench, a saturating 4-channel and a wrapping 3-channel instance side by side
module tb_dsp_addsub_acc;
  typedef struct {
    logic [15:0] d;
    logic        o;
    logic [1:0]  c;
  } exp_t;
  logic clk, reset_n, in_valid, acc_clr, out_ready;
  logic [1:0] in_op, in_ch;
  logic [15:0] in_a, in_b;
  logic rdy [2];
  logic ov [2];
  logic oo [2];
  logic [1:0] oc [2];
  logic [15:0] od [2];
  exp_t q [2][$];
  int n_cmp = 0;
  int n_err = 0;
  dsp_addsub_acc #(.WIDTH(16), .NCH(4), .SAT(1)) u_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[0]), .in_op(in_op),
    .in_ch(in_ch), .in_a(in_a), .in_b(in_b), .acc_clr(acc_clr), .out_valid(ov[0]),
    .out_ready(out_ready), .out_ch(oc[0]), .out_data(od[0]), .out_ovf(oo[0])
  );
  dsp_addsub_acc #(.WIDTH(16), .NCH(3), .SAT(0)) u_wrap (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[1]), .in_op(in_op),
    .in_ch(in_ch), .in_a(in_a), .in_b(in_b), .acc_clr(acc_clr), .out_valid(ov[1]),
    .out_ready(out_ready), .out_ch(oc[1]), .out_data(od[1]), .out_ovf(oo[1])
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Monitor: every output transfer is compared against the head of that instance's queue
  always @(negedge clk)
    for (int d = 0; d < 2; d++)
      if (ov[d] && out_ready) begin
        if (q[d].size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out dut%0d: got data %h with nothing expected", d, od[d]);
        end else begin
          exp_t e;
          e = q[d].pop_front();
          n_cmp++;
          if (od[d] !== e.d || oo[d] !== e.o || oc[d] !== e.c) begin
            n_err++;
            $display("FAIL result dut%0d: got data %h ovf %b ch %0d want data %h ovf %b ch %0d",
                     d, od[d], oo[d], oc[d], e.d, e.o, e.c);
          end
        end
      end
  task automatic send(input logic [1:0] op, input logic [1:0] ch, input logic [15:0] a,
                      input logic [15:0] b, input logic clr, input logic [15:0] es,
                      input logic os, input logic [15:0] ew, input logic ow);
    int k;
    q[0].push_back('{es, os, ch});
    q[1].push_back('{ew, ow, ch});
    in_op = op;
    in_ch = ch;
    in_a = a;
    in_b = b;
    acc_clr = clr;
    in_valid = 1'b1;
    k = 0;
    while (!(rdy[0] && rdy[1]) && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k == 50) chk("accept_timeout", 32'(rdy[0] && rdy[1]), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_clr = 1'b0;
  endtask
  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_op = '0;
    in_ch = '0;
    in_a = '0;
    in_b = '0;
    acc_clr = 1'b0;
    out_ready = 1'b1;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", 32'(ov[d]), 0);
      chk("rst_data", 32'(od[d]), 0);
      chk("rst_ovf", 32'(oo[d]), 0);
      chk("rst_ch", 32'(oc[d]), 0);
    end
    #10 reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) chk("ready_after_rst", 32'(rdy[d]), 1);
    send(2'd0, 2'd0, 16'd100, 16'hFFE2, 1'b0, 16'd70, 1'b0, 16'd70, 1'b0);
    send(2'd2, 2'd2, 16'h7000, 16'h0, 1'b0, 16'h7000, 1'b0, 16'h7000, 1'b0);
    send(2'd2, 2'd2, 16'h7000, 16'h0, 1'b0, 16'h7FFF, 1'b1, 16'hE000, 1'b1);
    send(2'd2, 2'd2, 16'h0, 16'h0, 1'b0, 16'h7FFF, 1'b0, 16'hE000, 1'b0);
    send(2'd2, 2'd1, 16'd40, 16'h0, 1'b0, 16'd40, 1'b0, 16'd40, 1'b0);
    send(2'd2, 2'd3, 16'd9, 16'h0, 1'b0, 16'd9, 1'b0, 16'd0, 1'b1);
    send(2'd3, 2'd1, 16'd5, 16'h0, 1'b1, 16'hFFFB, 1'b0, 16'hFFFB, 1'b0);
    send(2'd2, 2'd3, 16'h0, 16'h0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
    send(2'd2, 2'd1, 16'h0, 16'h0, 1'b0, 16'hFFFB, 1'b0, 16'hFFFB, 1'b0);
    send(2'd2, 2'd2, 16'h0, 16'h0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
    send(2'd3, 2'd0, 16'h8000, 16'h0, 1'b0, 16'h7FFF, 1'b1, 16'h8000, 1'b1);
    send(2'd1, 2'd0, 16'h8000, 16'h1, 1'b0, 16'h8000, 1'b1, 16'h7FFF, 1'b1);
    send(2'd2, 2'd0, 16'h0, 16'h0, 1'b0, 16'h7FFF, 1'b0, 16'h8000, 1'b0);
    send(2'd0, 2'd0, 16'h7FFF, 16'h1, 1'b0, 16'h7FFF, 1'b1, 16'h8000, 1'b1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(2'd0, 2'd1, 16'd3, 16'd4, 1'b0, 16'd7, 1'b0, 16'd7, 1'b0);
    q[0].push_back('{16'hFFFB, 1'b0, 2'd1});
    q[1].push_back('{16'hFFFB, 1'b0, 2'd1});
    in_op = 2'd2;
    in_ch = 2'd1;
    in_a = 16'h0;
    in_b = 16'h0;
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        chk("stall_ready", 32'(rdy[d]), 0);
        chk("stall_valid", 32'(ov[d]), 1);
        chk("stall_data", 32'(od[d]), 7);
      end
    end
    out_ready = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) chk("release_ready", 32'(rdy[d]), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(2'd2, 2'd2, 16'd11, 16'h0, 1'b0, 16'd11, 1'b0, 16'd11, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) chk("async_rst_valid", 32'(ov[d]), 0);
    q[0].delete();
    q[1].delete();
    #3 reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) chk("ready_after_rst2", 32'(rdy[d]), 1);
    send(2'd2, 2'd2, 16'h0, 16'h0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
    send(2'd2, 2'd1, 16'h0, 16'h0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
    send(2'd2, 2'd0, 16'h0, 16'h0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) chk("queue_drained", 32'(q[d].size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
